// File: rtl/axis_frame_arbiter_pkg.sv
// Shared types and helpers for the AXI-Stream frame arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_frame_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } axis_arb_state_t;

    // Width of a source index; a single source still needs one bit.
    function automatic int calc_id_width(input int s_count);
        int w;
        w = $clog2(s_count);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Round-robin priority encoder: first set request searching upward from last_idx+1, wrapping.
// Latency: purely combinational.
// Backpressure: none; vld is low when no request is set.
module rr_priority_encoder #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_idx,
    output logic          vld,
    output logic [IW-1:0] idx
);

    int cand;

    // Scan N candidates starting just after the last grant; the first hit wins.
    always_comb begin
        vld  = 1'b0;
        idx  = last_idx;
        cand = 0;
        for (int k = 1; k <= N; k++) begin
            cand = (int'(last_idx) + k) % N;
            if (!vld && req[cand]) begin
                vld = 1'b1;
                idx = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/axis_frame_arbiter.sv
// Frame-level round-robin arbiter: one source owns the output from grant until its tlast beat.
// Latency: first beat 2 cycles from valid (1 arbitration + 1 register), following beats 1 cycle.
// Backpressure: granted tready = m_axis_tready || !m_axis_tvalid; all other sources held off.
module axis_frame_arbiter
    import axis_frame_arbiter_pkg::*;
#(
    parameter  int S_COUNT    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int USER_WIDTH = 1,
    localparam int ID_WIDTH   = calc_id_width(S_COUNT)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [S_COUNT*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [S_COUNT-1:0]            s_axis_tvalid,
    output logic [S_COUNT-1:0]            s_axis_tready,
    input  logic [S_COUNT-1:0]            s_axis_tlast,
    input  logic [S_COUNT*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [ID_WIDTH-1:0]           m_axis_tid,
    output logic [USER_WIDTH-1:0]         m_axis_tuser,
    output logic                          busy,
    output logic [ID_WIDTH-1:0]           grant_index
);

    axis_arb_state_t       state, state_nxt;
    logic [ID_WIDTH-1:0]   grant_nxt;
    logic                  enc_vld;
    logic [ID_WIDTH-1:0]   enc_idx;
    logic                  out_room;
    logic                  accept;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;
    logic                  sel_last;

    rr_priority_encoder #(
        .N  (S_COUNT),
        .IW (ID_WIDTH)
    ) u_rr_enc (
        .req      (s_axis_tvalid),
        .last_idx (grant_index),
        .vld      (enc_vld),
        .idx      (enc_idx)
    );

    // The output register can take a beat when it is empty or draining this cycle.
    assign out_room = m_axis_tready || !m_axis_tvalid;
    assign accept   = (state == BUSY) && s_axis_tvalid[grant_index] && out_room;
    assign sel_data = s_axis_tdata[grant_index*DATA_WIDTH +: DATA_WIDTH];
    assign sel_user = s_axis_tuser[grant_index*USER_WIDTH +: USER_WIDTH];
    assign sel_last = s_axis_tlast[grant_index];
    assign busy     = (state == BUSY);

    // Only the granted source sees ready, and only while a grant is held.
    always_comb begin
        s_axis_tready = '0;
        if (state == BUSY) begin
            s_axis_tready[grant_index] = out_room;
        end
    end

    // State and round-robin pointer; grant_index survives the frame as the search origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            grant_index <= ID_WIDTH'(S_COUNT - 1);
        end else begin
            state       <= state_nxt;
            grant_index <= grant_nxt;
        end
    end

    // Grant in IDLE (no beat taken that cycle); release after the tlast beat is accepted.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant_index;
        case (state)
            IDLE: begin
                if (enc_vld) begin
                    state_nxt = BUSY;
                    grant_nxt = enc_idx;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Output valid: set on an accepted beat, cleared once the held beat is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_axis_tvalid <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    // Output payload needs no reset; it is only meaningful while m_axis_tvalid is high.
    always_ff @(posedge clk) begin
        if (accept) begin
            m_axis_tdata <= sel_data;
            m_axis_tlast <= sel_last;
            m_axis_tuser <= sel_user;
            m_axis_tid   <= grant_index;
        end
    end

endmodule

// File: tb/tb_axis_frame_arbiter.sv
module tb_axis_frame_arbiter;

    localparam int S  = 4;
    localparam int DW = 8;
    localparam int UW = 1;
    localparam int IW = 2;
    localparam int MAXB = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [S*DW-1:0] s_tdata;
    logic [S-1:0]    s_tvalid;
    logic [S-1:0]    s_tready;
    logic [S-1:0]    s_tlast;
    logic [S*UW-1:0] s_tuser;
    logic [DW-1:0]   m_tdata;
    logic            m_tvalid;
    logic            m_rdy;
    logic            m_tlast;
    logic [IW-1:0]   m_tid;
    logic [UW-1:0]   m_tuser;
    logic            busy;
    logic [IW-1:0]   grant_index;

    axis_frame_arbiter #(
        .S_COUNT    (S),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_tready),
        .s_axis_tlast  (s_tlast),
        .s_axis_tuser  (s_tuser),
        .m_axis_tdata  (m_tdata),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tready (m_rdy),
        .m_axis_tlast  (m_tlast),
        .m_axis_tid    (m_tid),
        .m_axis_tuser  (m_tuser),
        .busy          (busy),
        .grant_index   (grant_index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] tid;
        logic [DW-1:0] dat;
        logic          last;
        logic [UW-1:0] user;
    } beat_t;

    beat_t log_q[$];

    logic [DW-1:0] src_data [S][MAXB];
    logic          src_lastv[S][MAXB];
    int            src_len  [S];
    int            src_ptr  [S];
    bit            src_en   [S];

    logic          snap_vld, snap_last, snap_busy;
    logic [DW-1:0] snap_dat;
    logic [IW-1:0] snap_tid, snap_gnt;
    logic [S-1:0]  snap_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic clear_sources();
        for (int i = 0; i < S; i++) begin
            src_len[i] = 0;
            src_ptr[i] = 0;
            src_en[i]  = 1'b0;
            for (int b = 0; b < MAXB; b++) begin
                src_data[i][b]  = '0;
                src_lastv[i][b] = 1'b0;
            end
        end
    endtask

    // Load 'len' beats on source 'src', data base+b, tlast every 'flen' beats.
    task automatic load_src(input int src, input int len, input logic [DW-1:0] base, input int flen);
        src_len[src] = len;
        src_ptr[src] = 0;
        src_en[src]  = 1'b1;
        for (int b = 0; b < len; b++) begin
            src_data[src][b]  = base + DW'(b);
            src_lastv[src][b] = ((b % flen) == flen - 1);
        end
    endtask

    // One clock: drive sources, sample mid-cycle, advance on handshakes after the edge.
    task automatic step();
        logic [S-1:0] acc;
        for (int i = 0; i < S; i++) begin
            int p;
            p = (src_ptr[i] < src_len[i]) ? src_ptr[i] : 0;
            s_tvalid[i]          = src_en[i] && (src_ptr[i] < src_len[i]);
            s_tdata[i*DW +: DW]  = src_data[i][p];
            s_tlast[i]           = src_lastv[i][p];
            s_tuser[i*UW +: UW]  = UW'(i & 1);
        end
        #1;
        snap_vld  = m_tvalid;
        snap_dat  = m_tdata;
        snap_last = m_tlast;
        snap_tid  = m_tid;
        snap_busy = busy;
        snap_gnt  = grant_index;
        snap_rdy  = s_tready;
        acc       = s_tvalid & s_tready;
        if (m_tvalid && m_rdy) begin
            beat_t bt;
            bt.tid  = m_tid;
            bt.dat  = m_tdata;
            bt.last = m_tlast;
            bt.user = m_tuser;
            log_q.push_back(bt);
        end
        @(posedge clk);
        for (int i = 0; i < S; i++) begin
            if (acc[i]) src_ptr[i]++;
        end
        #1;
    endtask

    task automatic run_until(input int n, input int budget);
        int c;
        c = 0;
        while (log_q.size() < n && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        m_rdy = 1'b1;
        clear_sources();
        step();
        step();
        rst = 1'b0;
        log_q.delete();
    endtask

    task automatic check_beat(input string name, input int k, input logic [IW-1:0] tid,
                              input logic [DW-1:0] dat, input logic last);
        n_tests++;
        if (k >= log_q.size()) begin
            n_fail++;
            $display("FAIL %s beat %0d missing (got %0d beats)", name, k, log_q.size());
        end else if (log_q[k].tid !== tid || log_q[k].dat !== dat || log_q[k].last !== last) begin
            n_fail++;
            $display("FAIL %s beat %0d: got tid=%0d dat=%h last=%b, want tid=%0d dat=%h last=%b",
                     name, k, log_q[k].tid, log_q[k].dat, log_q[k].last, tid, dat, last);
        end
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) step();
        n_tests++;
        if (snap_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld got %b want 0", snap_vld); end
        n_tests++;
        if (snap_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", snap_busy); end
        n_tests++;
        if (snap_rdy !== 4'b0000) begin n_fail++; $display("FAIL reset_tready got %b want 0000", snap_rdy); end
        n_tests++;
        if (snap_gnt !== 2'd3) begin n_fail++; $display("FAIL reset_grant got %0d want 3", snap_gnt); end
    endtask

    task automatic test_single_source();
        logic [DW-1:0] exp_d [5];
        logic          exp_v [5];
        logic          exp_l [5];
        logic          exp_b [5];
        exp_v = '{0, 0, 1, 1, 1};
        exp_d = '{8'h00, 8'h00, 8'hA1, 8'hA2, 8'hA3};
        exp_l = '{0, 0, 0, 0, 1};
        exp_b = '{0, 1, 1, 1, 0};
        do_reset();
        load_src(2, 3, 8'hA1, 3);
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++;
            if (snap_vld !== exp_v[c] || snap_busy !== exp_b[c] ||
                (exp_v[c] && (snap_dat !== exp_d[c] || snap_last !== exp_l[c] || snap_tid !== 2'd2))) begin
                n_fail++;
                $display("FAIL single_c%0d: got vld=%b busy=%b dat=%h last=%b tid=%0d, want vld=%b busy=%b dat=%h last=%b tid=2",
                         c, snap_vld, snap_busy, snap_dat, snap_last, snap_tid,
                         exp_v[c], exp_b[c], exp_d[c], exp_l[c]);
            end
            if (c == 1) begin
                n_tests++;
                if (snap_gnt !== 2'd2 || snap_rdy !== 4'b0100) begin
                    n_fail++;
                    $display("FAIL single_grant got gnt=%0d rdy=%b want gnt=2 rdy=0100", snap_gnt, snap_rdy);
                end
            end
        end
        step();
        n_tests++;
        if (snap_vld !== 1'b0) begin n_fail++; $display("FAIL single_drain got vld=%b want 0", snap_vld); end
    endtask

    task automatic test_rotation();
        do_reset();
        for (int i = 0; i < S; i++) load_src(i, 4, DW'(8'h10 * i), 2);
        run_until(16, 100);
        for (int k = 0; k < 8; k++) begin
            for (int b = 0; b < 2; b++) begin
                check_beat("rotation", 2 * k + b, IW'(k % 4),
                           DW'(8'h10 * (k % 4) + 2 * (k / 4) + b), (b == 1));
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        load_src(0, 4, 8'h40, 4);
        step();
        step();
        m_rdy = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            n_tests++;
            if (snap_vld !== 1'b1 || snap_dat !== 8'h40 || snap_tid !== 2'd0 ||
                snap_last !== 1'b0 || snap_rdy !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold_c%0d: got vld=%b dat=%h tid=%0d last=%b rdy=%b, want 1 40 0 0 0000",
                         c, snap_vld, snap_dat, snap_tid, snap_last, snap_rdy);
            end
        end
        m_rdy = 1'b1;
        run_until(4, 20);
        for (int k = 0; k < 4; k++) check_beat("bp_release", k, 2'd0, DW'(8'h40 + k), (k == 3));
        step();
        step();
        n_tests++;
        if (log_q.size() !== 4) begin
            n_fail++;
            $display("FAIL bp_count got %0d beats want 4", log_q.size());
        end
    endtask

    task automatic test_stall_contention();
        do_reset();
        load_src(1, 3, 8'h51, 3);
        load_src(3, 1, 8'h5F, 1);
        step();
        step();
        src_en[1] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_tests++;
            if (snap_rdy[3] !== 1'b0 || snap_busy !== 1'b1 || snap_gnt !== 2'd1) begin
                n_fail++;
                $display("FAIL stall_c%0d: got rdy=%b busy=%b gnt=%0d, want rdy3=0 busy=1 gnt=1",
                         c, snap_rdy, snap_busy, snap_gnt);
            end
        end
        src_en[1] = 1'b1;
        run_until(4, 30);
        check_beat("stall", 0, 2'd1, 8'h51, 1'b0);
        check_beat("stall", 1, 2'd1, 8'h52, 1'b0);
        check_beat("stall", 2, 2'd1, 8'h53, 1'b1);
        check_beat("stall", 3, 2'd3, 8'h5F, 1'b1);
        n_tests++;
        if (log_q.size() >= 4 && log_q[3].user !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_user got %b want 1", log_q[3].user);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        load_src(0, 4, 8'h60, 4);
        step();
        step();
        step();
        #2;
        rst = 1'b1;
        #1;
        n_tests++;
        if (m_tvalid !== 1'b0 || busy !== 1'b0 || grant_index !== 2'd3 || s_tready !== 4'b0000) begin
            n_fail++;
            $display("FAIL async_rst got vld=%b busy=%b gnt=%0d rdy=%b, want 0 0 3 0000",
                     m_tvalid, busy, grant_index, s_tready);
        end
        clear_sources();
        step();
        step();
        rst = 1'b0;
        log_q.delete();
        load_src(3, 1, 8'h6F, 1);
        load_src(0, 1, 8'h70, 1);
        run_until(2, 20);
        check_beat("post_rst", 0, 2'd0, 8'h70, 1'b1);
        check_beat("post_rst", 1, 2'd3, 8'h6F, 1'b1);
    endtask

    initial begin
        s_tdata  = '0;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tuser  = '0;
        m_rdy    = 1'b1;
        clear_sources();
        test_reset();
        test_single_source();
        test_rotation();
        test_backpressure();
        test_stall_contention();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
